// File: rtl/count_up_pkg.sv
// Shared widths and active-low 7-segment patterns ({g,f,e,d,c,b,a}) for the count/display slice.
package count_up_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Prescaler width: clog2 of the divide ratio, never narrower than one bit.
  function automatic int unsigned pre_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex digit to active-low 7-segment decoder.
//   digit in  [3:0]  value to display
//   seg   out [6:0]  segment pattern {g,f,e,d,c,b,a}, active-low
module hex_seg_decoder
  import count_up_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_up_display.sv
// Prescaled 4-bit up counter with sync clear/load and a registered 7-segment digit.
//   clk, rst_n         clock, async active-low reset
//   en                 count enable; low freezes prescaler and count
//   clr, load          sync clear / sync load of load_val (clr wins)
//   load_val [3:0]     load value, saturated to MAX_COUNT
//   count    [3:0]     current count
//   hex      [6:0]     decode(count), one clk behind count, active-low
//   tick, wrap         1-cycle pulses aligned with the new count after an advance / MAX->0 advance
module count_up_display
  import count_up_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] count,
  output logic [SEG_W-1:0]   hex,
  output logic               tick,
  output logic               wrap
);

  localparam int unsigned PRE_W = pre_width(TICK_DIV);

  logic [PRE_W-1:0]   pre;
  logic               step_c;
  logic               at_max_c;
  logic [DIGIT_W-1:0] load_sat_c;
  logic [DIGIT_W-1:0] next_count_c;
  logic [SEG_W-1:0]   seg_c;

  // Step decision and next-value helpers.
  assign step_c       = en && (pre == PRE_W'(TICK_DIV - 1));
  assign at_max_c     = (count == DIGIT_W'(MAX_COUNT));
  assign load_sat_c   = (load_val > DIGIT_W'(MAX_COUNT)) ? DIGIT_W'(MAX_COUNT) : load_val;
  assign next_count_c = at_max_c ? '0 : count + DIGIT_W'(1);

  // Prescaler, count and event pulses; clr > load > step > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (clr) begin
      pre   <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      pre   <= '0;
      count <= load_sat_c;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (step_c) begin
      pre   <= '0;
      count <= next_count_c;
      tick  <= 1'b1;
      wrap  <= at_max_c;
    end else begin
      if (en) begin
        pre <= pre + PRE_W'(1);
      end
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  hex_seg_decoder u_dec (
    .digit (count),
    .seg   (seg_c)
  );

  // Display register: follows count with one clk of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex <= SEG_0;
    end else begin
      hex <= seg_c;
    end
  end

endmodule
